wb_stage: RTL



---
 rtl/wb_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, waits for load data when
// needed, aligns the result and drives the register-file write port for one
// cycle per instruction. Also keeps the 64-bit retired-instruction counter.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | empty, ready to accept an instruction
// ST_WAIT   | load captured, waiting for dmem_rvld_i
// ST_COMMIT | write port / retire pulse active this cycle, ready to accept
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_vld_i,
    output logic              wb_ready_o,
    input  logic [DATA_W-1:0] mem_pc_i,
    input  logic [REG_W-1:0]  mem_rd_i,
    input  logic              mem_rd_we_i,
    input  logic [1:0]        mem_wb_sel_i,
    input  logic [DATA_W-1:0] mem_alu_res_i,
    input  logic [2:0]        mem_ld_type_i,
    input  logic              dmem_rvld_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [REG_W-1:0]  reg_waddr_o,
    output logic              reg_waddr_vld_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              retire_o,
    output logic [DATA_W-1:0] retire_pc_o,
    output logic [63:0]       instret_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [1:0]        state_q,   state_d;
    logic [REG_W-1:0]  rd_q,      rd_d;
    logic              rd_we_q,   rd_we_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        ld_type_q, ld_type_d;

    logic [REG_W-1:0]  waddr_q,   waddr_d;
    logic              wvld_q,    wvld_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              retire_q,  retire_d;
    logic [DATA_W-1:0] rpc_q,     rpc_d;
    logic [63:0]       instret_q, instret_d;

    logic              xfer;
    logic [DATA_W-1:0] load_data;

    // Ready decodes from state only, so there is no path from mem_vld_i.
    assign wb_ready_o = (state_q != ST_WAIT);
    assign xfer       = mem_vld_i && wb_ready_o;

    // Extract and extend the addressed byte/half from the raw load word.
    always_comb begin
        logic [DATA_W-1:0] shifted;
        logic [15:0]       half;
        shifted   = dmem_rdata_i >> {addr_lo_q, 3'b000};
        half      = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_data = dmem_rdata_i;
        case (ld_type_q)
            3'b000:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(DATA_W-16){half[15]}}, half};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, half};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // Next-state, capture and commit-output selection.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        pc_d      = pc_q;
        addr_lo_d = addr_lo_q;
        ld_type_d = ld_type_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        rpc_d     = rpc_q;
        wvld_d    = 1'b0;
        retire_d  = 1'b0;
        instret_d = instret_q + ((state_q == ST_COMMIT) ? 64'd1 : 64'd0);

        case (state_q)
            ST_WAIT: begin
                if (dmem_rvld_i) begin
                    state_d  = ST_COMMIT;
                    waddr_d  = rd_q;
                    wvld_d   = rd_we_q;
                    wdata_d  = load_data;
                    rpc_d    = pc_q;
                    retire_d = 1'b1;
                end
            end
            default: begin
                // IDLE and COMMIT both accept; load data seen here is ignored.
                if (xfer) begin
                    rd_d      = mem_rd_i;
                    rd_we_d   = mem_rd_we_i;
                    pc_d      = mem_pc_i;
                    addr_lo_d = mem_alu_res_i[1:0];
                    ld_type_d = mem_ld_type_i;
                    if (mem_wb_sel_i == SEL_LOAD) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d  = ST_COMMIT;
                        waddr_d  = mem_rd_i;
                        wvld_d   = mem_rd_we_i;
                        wdata_d  = (mem_wb_sel_i == SEL_PC4) ?
                                   mem_pc_i + DATA_W'(4) : mem_alu_res_i;
                        rpc_d    = mem_pc_i;
                        retire_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset wins over any transfer or load data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            pc_q      <= '0;
            addr_lo_q <= '0;
            ld_type_q <= '0;
            waddr_q   <= '0;
            wvld_q    <= 1'b0;
            wdata_q   <= '0;
            retire_q  <= 1'b0;
            rpc_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            pc_q      <= pc_d;
            addr_lo_q <= addr_lo_d;
            ld_type_q <= ld_type_d;
            waddr_q   <= waddr_d;
            wvld_q    <= wvld_d;
            wdata_q   <= wdata_d;
            retire_q  <= retire_d;
            rpc_q     <= rpc_d;
            instret_q <= instret_d;
        end
    end

    assign reg_waddr_o     = waddr_q;
    assign reg_waddr_vld_o = wvld_q;
    assign reg_wdata_o     = wdata_q;
    assign retire_o        = retire_q;
    assign retire_pc_o     = rpc_q;
    assign instret_o       = instret_q;

endmodule
